lsp_stage_sequencer: RTL and testbench

//  Sequences the Qua_Lsp search stages (pre-select, select_1, select_2, get_tdist) that share one

---
 rtl/lsp_stage_sequencer_pkg.sv | 26 ++
 rtl/lsp_seq_watchdog.sv | 45 ++++
 rtl/lsp_stage_sequencer.sv | 178 +++++++++++++++++
 tb/tb_lsp_stage_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsp_stage_sequencer_pkg.sv
// ============================================================================
// lsp_stage_sequencer_pkg : shared state encoding and default widths
// Rev 1.0
// ============================================================================
`default_nettype none

package lsp_stage_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_FINISH = 3'd3,
    ST_ABORT  = 3'd4
  } seq_state_e;

  localparam int DEF_NUM_STAGES = 4;
  localparam int DEF_IDX_W      = 2;
  localparam int DEF_ADDR_W     = 12;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_TIMEOUT    = 4095;
  localparam int WDOG_W         = 16;

endpackage

`default_nettype wire

// File: rtl/lsp_seq_watchdog.sv
// ============================================================================
// lsp_seq_watchdog : clear/enable cycle counter with terminal-count flag
// Rev 1.0
// ============================================================================
`default_nettype none

module lsp_seq_watchdog
  import lsp_stage_sequencer_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam logic [WDOG_W-1:0] TERM_COUNT = WDOG_W'(TIMEOUT - 1);

  logic [WDOG_W-1:0] count_q;
  logic [WDOG_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + WDOG_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == TERM_COUNT);

endmodule

`default_nettype wire

// File: rtl/lsp_stage_sequencer.sv
// ============================================================================
// lsp_stage_sequencer : chains the Qua_Lsp search stages and arbitrates the
//                       shared scratch memory port between stages and test port
// Rev 1.0
// ============================================================================
`default_nettype none

module lsp_stage_sequencer
  import lsp_stage_sequencer_pkg::*;
#(
  parameter int NUM_STAGES = DEF_NUM_STAGES,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         test_sel,
  input  logic [ADDR_W-1:0]            testReadRequested,
  input  logic [ADDR_W-1:0]            testWriteRequested,
  input  logic [DATA_W-1:0]            testWriteOut,
  input  logic                         testWrite,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_readAddr,
  input  logic [NUM_STAGES*ADDR_W-1:0] stage_writeAddr,
  input  logic [NUM_STAGES*DATA_W-1:0] stage_writeOut,
  input  logic [NUM_STAGES-1:0]        stage_writeEn,
  input  logic [NUM_STAGES-1:0]        stage_done,
  output logic [NUM_STAGES-1:0]        stage_start,
  output logic [ADDR_W-1:0]            mem_readAddr,
  output logic [ADDR_W-1:0]            mem_writeAddr,
  output logic [DATA_W-1:0]            mem_writeOut,
  output logic                         mem_writeEn,
  output logic [IDX_W-1:0]             cur_stage,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(NUM_STAGES - 1);

  seq_state_e              state_q, state_d;
  logic [IDX_W-1:0]        cur_stage_q, cur_stage_d;
  logic [NUM_STAGES-1:0]   stage_start_q, stage_start_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    wd_clear;
  logic                    wd_enable;
  logic                    wd_terminal;
  logic                    cur_done;

  logic [ADDR_W-1:0]       rd_addr_a [NUM_STAGES];
  logic [ADDR_W-1:0]       wr_addr_a [NUM_STAGES];
  logic [DATA_W-1:0]       wr_data_a [NUM_STAGES];

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_unpack
    assign rd_addr_a[g] = stage_readAddr[g*ADDR_W +: ADDR_W];
    assign wr_addr_a[g] = stage_writeAddr[g*ADDR_W +: ADDR_W];
    assign wr_data_a[g] = stage_writeOut[g*DATA_W +: DATA_W];
  end

  lsp_seq_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (wd_clear),
    .enable   (wd_enable),
    .terminal (wd_terminal)
  );

  // Done from any stage other than the granted one is deliberately ignored.
  assign cur_done = stage_done[cur_stage_q];

  always_comb begin
    state_d     = state_q;
    cur_stage_d = cur_stage_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    wd_clear    = 1'b0;
    wd_enable   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_LAUNCH;
          cur_stage_d = '0;
          err_d       = 1'b0;
          busy_d      = 1'b1;
        end
      end
      ST_LAUNCH: begin
        wd_clear = 1'b1;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        wd_enable = 1'b1;
        if (cur_done) begin
          if (cur_stage_q == LAST_STAGE) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            cur_stage_d = cur_stage_q + IDX_W'(1);
            state_d     = ST_LAUNCH;
          end
        end else if (wd_terminal) begin
          state_d = ST_ABORT;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end
      end
      ST_FINISH, ST_ABORT: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Start pulse is registered so it lands exactly in the LAUNCH cycle.
    stage_start_d = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_start_d[i] = (state_d == ST_LAUNCH) && (cur_stage_d == IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cur_stage_q   <= '0;
      stage_start_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_stage_q   <= cur_stage_d;
      stage_start_q <= stage_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  // While a run is in progress the test port is locked out regardless of test_sel.
  always_comb begin
    mem_readAddr  = '0;
    mem_writeAddr = '0;
    mem_writeOut  = '0;
    mem_writeEn   = 1'b0;
    if (busy_q) begin
      mem_readAddr  = rd_addr_a[cur_stage_q];
      mem_writeAddr = wr_addr_a[cur_stage_q];
      mem_writeOut  = wr_data_a[cur_stage_q];
      mem_writeEn   = stage_writeEn[cur_stage_q];
    end else if (test_sel) begin
      mem_readAddr  = testReadRequested;
      mem_writeAddr = testWriteRequested;
      mem_writeOut  = testWriteOut;
      mem_writeEn   = testWrite;
    end
  end

  assign stage_start = stage_start_q;
  assign cur_stage   = cur_stage_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

`default_nettype wire

// File: tb/tb_lsp_stage_sequencer.sv
// ============================================================================
// tb_lsp_stage_sequencer : self-checking bench for lsp_stage_sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_lsp_stage_sequencer;

  localparam int NS = 4;
  localparam int IW = 2;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           test_sel;
  logic [AW-1:0]  testReadRequested;
  logic [AW-1:0]  testWriteRequested;
  logic [DW-1:0]  testWriteOut;
  logic           testWrite;
  logic [NS*AW-1:0] stage_readAddr;
  logic [NS*AW-1:0] stage_writeAddr;
  logic [NS*DW-1:0] stage_writeOut;
  logic [NS-1:0]  stage_writeEn;
  logic [NS-1:0]  stage_done;
  logic [NS-1:0]  stage_start;
  logic [AW-1:0]  mem_readAddr;
  logic [AW-1:0]  mem_writeAddr;
  logic [DW-1:0]  mem_writeOut;
  logic           mem_writeEn;
  logic [IW-1:0]  cur_stage;
  logic           busy;
  logic           done;
  logic           err;

  always #5 clk = ~clk;

  lsp_stage_sequencer #(
    .NUM_STAGES (NS),
    .IDX_W      (IW),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .TIMEOUT    (TO)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .start              (start),
    .test_sel           (test_sel),
    .testReadRequested  (testReadRequested),
    .testWriteRequested (testWriteRequested),
    .testWriteOut       (testWriteOut),
    .testWrite          (testWrite),
    .stage_readAddr     (stage_readAddr),
    .stage_writeAddr    (stage_writeAddr),
    .stage_writeOut     (stage_writeOut),
    .stage_writeEn      (stage_writeEn),
    .stage_done         (stage_done),
    .stage_start        (stage_start),
    .mem_readAddr       (mem_readAddr),
    .mem_writeAddr      (mem_writeAddr),
    .mem_writeOut       (mem_writeOut),
    .mem_writeEn        (mem_writeEn),
    .cur_stage          (cur_stage),
    .busy               (busy),
    .done               (done),
    .err                (err)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int prev_cur = 0;
  bit prev_err = 1'b0;
  int lat_cfg [NS];

  typedef struct {
    logic          sel;
    logic [AW-1:0] ra;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          we;
    logic [AW-1:0] exp_ra;
    logic [AW-1:0] exp_wa;
    logic [DW-1:0] exp_wd;
    logic          exp_we;
  } vec_t;

  vec_t vt [5];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=0x%0h expected=0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // mode 0: quiet random data; 1: stage 0 holds writeEn, stage 2 writes 0x0A0;
  // 2: stray done pulses on non-granted stages plus start/test_sel noise.
  task automatic rand_inputs(input int mode, input int cur);
    test_sel           = 1'($urandom_range(0, 1));
    testReadRequested  = AW'($urandom);
    testWriteRequested = AW'($urandom);
    testWriteOut       = $urandom;
    testWrite          = 1'($urandom_range(0, 1));
    start              = 1'b0;
    stage_done         = '0;
    for (int i = 0; i < NS; i++) begin
      stage_readAddr[i*AW +: AW]  = AW'($urandom);
      stage_writeAddr[i*AW +: AW] = AW'($urandom);
      stage_writeOut[i*DW +: DW]  = $urandom;
      stage_writeEn[i]            = 1'($urandom_range(0, 1));
    end
    if (mode == 1) begin
      stage_writeEn[0]            = 1'b1;
      stage_writeAddr[2*AW +: AW] = 12'h0A0;
    end
    if (mode == 2) begin
      start = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < NS; j++) begin
        if (j != cur && $urandom_range(0, 3) == 0) stage_done[j] = 1'b1;
      end
    end
  endtask

  task automatic check_cycle(input bit e_busy, input bit e_done, input bit e_err,
                             input int e_cur, input logic [NS-1:0] e_start);
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    logic          we;
    if (e_busy) begin
      ra = stage_readAddr[e_cur*AW +: AW];
      wa = stage_writeAddr[e_cur*AW +: AW];
      wd = stage_writeOut[e_cur*DW +: DW];
      we = stage_writeEn[e_cur];
    end else if (test_sel) begin
      ra = testReadRequested;
      wa = testWriteRequested;
      wd = testWriteOut;
      we = testWrite;
    end else begin
      ra = '0; wa = '0; wd = '0; we = 1'b0;
    end
    #1;
    chk("stage_start", 64'(stage_start), 64'(e_start));
    chk("busy", 64'(busy), 64'(e_busy));
    chk("done", 64'(done), 64'(e_done));
    chk("err", 64'(err), 64'(e_err));
    chk("cur_stage", 64'(cur_stage), 64'(e_cur));
    chk("mem_readAddr", 64'(mem_readAddr), 64'(ra));
    chk("mem_writeAddr", 64'(mem_writeAddr), 64'(wa));
    chk("mem_writeOut", 64'(mem_writeOut), 64'(wd));
    chk("mem_writeEn", 64'(mem_writeEn), 64'(we));
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      rand_inputs(0, prev_cur);
      check_cycle(1'b0, 1'b0, prev_err, prev_cur, '0);
      tick();
    end
  endtask

  // Reference timeline: stage i starts one cycle after the previous stage's
  // done, a stage is accepted if its done arrives within TO cycles after its
  // start cycle, otherwise the run ends TO+1 cycles after that start.
  task automatic do_run(input int mode);
    int s [NS];
    int obs [NS];
    int nl, d, c0;
    bit ab;
    c0 = cyc; nl = 0; ab = 1'b0; d = 0;
    for (int i = 0; i < NS; i++) begin
      s[i] = -1000; obs[i] = -1000;
    end
    s[0] = c0 + 1;
    for (int i = 0; i < NS; i++) begin
      nl = i + 1;
      if (lat_cfg[i] > TO) begin
        d  = s[i] + TO + 1;
        ab = 1'b1;
        break;
      end
      if (i == NS - 1) d = s[i] + lat_cfg[i] + 1;
      else             s[i+1] = s[i] + lat_cfg[i] + 1;
    end
    for (int x = c0; x <= d + 1; x++) begin
      int ec;
      bit eb, ed, ee;
      logic [NS-1:0] es;
      if (x <= c0) ec = prev_cur;
      else begin
        ec = 0;
        for (int i = 0; i < nl; i++) if (s[i] <= x) ec = i;
      end
      eb = (x >= s[0]) && (x <= d);
      ed = (x == d);
      ee = (x <= c0) ? prev_err : (ab && x >= d);
      es = '0;
      for (int i = 0; i < nl; i++) if (s[i] == x) es[i] = 1'b1;
      rand_inputs(mode, ec);
      if (x == c0)          start = 1'b1;
      else if (x == d + 1)  start = 1'b0;
      for (int i = 0; i < NS; i++) if (obs[i] + lat_cfg[i] == x) stage_done[i] = 1'b1;
      check_cycle(eb, ed, ee, ec, es);
      for (int i = 0; i < NS; i++) if (stage_start[i]) obs[i] = x;
      tick();
    end
    prev_cur = nl - 1;
    prev_err = ab;
  endtask

  task automatic set_lat(input int a, input int b, input int c, input int e);
    lat_cfg[0] = a; lat_cfg[1] = b; lat_cfg[2] = c; lat_cfg[3] = e;
  endtask

  initial begin
    vt[0] = '{1'b1, 12'h123, 12'h010, 32'hDEADBEEF, 1'b1, 12'h123, 12'h010, 32'hDEADBEEF, 1'b1};
    vt[1] = '{1'b0, 12'h123, 12'h010, 32'hDEADBEEF, 1'b1, 12'h000, 12'h000, 32'h00000000, 1'b0};
    vt[2] = '{1'b1, 12'hFFF, 12'hFFF, 32'hFFFFFFFF, 1'b0, 12'hFFF, 12'hFFF, 32'hFFFFFFFF, 1'b0};
    vt[3] = '{1'b0, 12'hFFF, 12'hABC, 32'h12345678, 1'b1, 12'h000, 12'h000, 32'h00000000, 1'b0};
    vt[4] = '{1'b1, 12'h000, 12'h800, 32'h00000001, 1'b1, 12'h000, 12'h800, 32'h00000001, 1'b1};

    reset = 1'b1;
    rand_inputs(0, 0);
    stage_writeEn = '1;
    tick();
    tick();
    chk("rst_stage_start", 64'(stage_start), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_cur_stage", 64'(cur_stage), 64'h0);
    reset = 1'b0;
    tick();

    // IDLE memory mux vectors, stages all requesting writes
    for (int v = 0; v < 5; v++) begin
      rand_inputs(0, 0);
      stage_writeEn      = '1;
      test_sel           = vt[v].sel;
      testReadRequested  = vt[v].ra;
      testWriteRequested = vt[v].wa;
      testWriteOut       = vt[v].wd;
      testWrite          = vt[v].we;
      #1;
      chk("vec_readAddr", 64'(mem_readAddr), 64'(vt[v].exp_ra));
      chk("vec_writeAddr", 64'(mem_writeAddr), 64'(vt[v].exp_wa));
      chk("vec_writeOut", 64'(mem_writeOut), 64'(vt[v].exp_wd));
      chk("vec_writeEn", 64'(mem_writeEn), 64'(vt[v].exp_we));
      tick();
    end

    idle_cycles(2);
    set_lat(5, 5, 5, 5);    do_run(1);
    idle_cycles(2);
    set_lat(5, 100, 5, 5);  do_run(0);
    idle_cycles(2);
    set_lat(5, 5, 5, 5);    do_run(2);
    idle_cycles(1);
    set_lat(1, 16, 17, 5);  do_run(2);
    set_lat(16, 1, 1, 16);  do_run(0);
    for (int r = 0; r < 8; r++) begin
      set_lat($urandom_range(1, 20), $urandom_range(1, 18),
              $urandom_range(1, 18), $urandom_range(1, 20));
      do_run(2);
      idle_cycles($urandom_range(0, 2));
    end

    // Reset during the WAIT of stage 2
    begin
      int obs [NS];
      bit seen2;
      for (int i = 0; i < NS; i++) obs[i] = -1000;
      seen2 = 1'b0;
      rand_inputs(0, 0);
      test_sel      = 1'b0;
      stage_writeEn = '1;
      start         = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 60 && !seen2; k++) begin
        stage_done = '0;
        for (int i = 0; i < 2; i++) if (obs[i] + 5 == cyc) stage_done[i] = 1'b1;
        #1;
        for (int i = 0; i < NS; i++) if (stage_start[i]) obs[i] = cyc;
        if (stage_start[2]) seen2 = 1'b1;
        tick();
      end
      stage_done = '0;
      chk("reach_stage2", 64'(seen2), 64'h1);
      tick();
      tick();
      chk("wait2_busy", 64'(busy), 64'h1);
      chk("wait2_cur", 64'(cur_stage), 64'h2);
      chk("wait2_we", 64'(mem_writeEn), 64'h1);
      reset = 1'b1;
      tick();
      chk("midrst_stage_start", 64'(stage_start), 64'h0);
      chk("midrst_busy", 64'(busy), 64'h0);
      chk("midrst_cur", 64'(cur_stage), 64'h0);
      chk("midrst_we", 64'(mem_writeEn), 64'h0);
      chk("midrst_done", 64'(done), 64'h0);
      reset = 1'b0;
      tick();
      chk("postrst_busy", 64'(busy), 64'h0);
      chk("postrst_start", 64'(stage_start), 64'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
